// File: rtl/force_release_pkg.sv
// force_release_pkg
//   Shared types and helpers for the force/release override bank.
//   - frc_state_t : per-channel override state (IDLE / HOLD / TIMED)
//   - idx_w()     : width of a channel index bus, never less than 1 bit
package force_release_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      TIMED = 2'd2
   } frc_state_t;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/force_release_chan.sv
// force_release_chan
//   One override channel: underlying storage register, override value,
//   force state machine and auto-release timer.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     wr, wr_data     normal write (already decoded for this channel)
//     frc, frc_val    force request and value (decoded)
//     frc_cycles      0 = indefinite force, N = force for exactly N cycles
//     rel             release request (decoded)
//     dout            effective value (override value while forced)
//     forced          1 while the override is active
//     rel_pulse       one-cycle pulse in the cycle after any release
//     frc_count       saturating force counter (only with FORCE_STATS_EN)
//   VAR_STYLE=0: net-style (storage keeps tracking writes; release reverts).
//   VAR_STYLE=1: variable-style (writes dropped while forced; release
//                copies the override value into storage).
//
//   state | meaning
//   IDLE  | not forced, dout follows storage
//   HOLD  | forced until an explicit release
//   TIMED | forced, timer counts down to an automatic release
module force_release_chan
   import force_release_pkg::*;
#(
   parameter int               WIDTH     = 5,
   parameter int               CNT_W     = 8,
   parameter bit               VAR_STYLE = 1'b0,
   parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             frc,
   input  logic [WIDTH-1:0] frc_val,
   input  logic [CNT_W-1:0] frc_cycles,
   input  logic             rel,
   output logic [WIDTH-1:0] dout,
   output logic             forced,
   output logic             rel_pulse
`ifdef FORCE_STATS_EN
   ,
   output logic [7:0]       frc_count
`endif
);

   frc_state_t       state, state_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic [WIDTH-1:0] storage, ovr_val;
   logic [WIDTH-1:0] store_d;
   logic             store_we;
   logic             leave;

   // A new force always wins over a release or a timer expiry in the same cycle.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      leave     = 1'b0;
      if (frc) begin
         state_nxt = (frc_cycles == '0) ? HOLD : TIMED;
         timer_nxt = frc_cycles;
      end else begin
         case (state)
            HOLD: begin
               if (rel) leave = 1'b1;
            end
            TIMED: begin
               if (rel || timer == CNT_W'(1)) leave = 1'b1;
               else                           timer_nxt = timer - 1'b1;
            end
            default: ;
         endcase
         if (leave) begin
            state_nxt = IDLE;
            timer_nxt = '0;
         end
      end
   end

   // Variable-style: a write landing on the release edge beats the copy-back.
   always_comb begin
      store_we = 1'b0;
      store_d  = wr_data;
      if (!VAR_STYLE) begin
         store_we = wr;
      end else if (leave) begin
         store_we = 1'b1;
         store_d  = wr ? wr_data : ovr_val;
      end else if (!frc && state == IDLE) begin
         store_we = wr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         storage   <= RST_VAL;
         ovr_val   <= '0;
         rel_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         rel_pulse <= leave;
         if (store_we) storage <= store_d;
         if (frc)      ovr_val <= frc_val;
      end
   end

`ifdef FORCE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          frc_count <= 8'd0;
      else if (frc && frc_count != 8'hFF)  frc_count <= frc_count + 8'd1;
   end
`endif

   assign forced = (state != IDLE);
   assign dout   = forced ? ovr_val : storage;

endmodule

// File: rtl/force_release_bank.sv
// force_release_bank
//   Bank of CHANNELS override registers sitting between register writers
//   and downstream consumers. Each channel can be forced (indefinitely or
//   for a number of cycles) and released; release behaviour per channel is
//   net-style or variable-style according to VAR_MASK.
//   Ports:
//     clk, rst_n                       clock, asynchronous active-low reset
//     wr_en, wr_ch, wr_data            normal register write
//     frc_en, frc_ch, frc_val,
//     frc_cycles                       force request (0 cycles = indefinite)
//     rel_en, rel_ch                   release request
//     dout                             effective values, ch c at [c*WIDTH +: WIDTH]
//     forced                           per-channel forced flags
//     rel_pulse                        per-channel release pulses
//     frc_count                        per-channel saturating force counts,
//                                      present only with FORCE_STATS_EN
//   Channel indices >= CHANNELS match no channel and are ignored.
module force_release_bank
   import force_release_pkg::*;
#(
   parameter int                  WIDTH    = 5,
   parameter int                  CHANNELS = 4,
   parameter int                  CNT_W    = 8,
   parameter logic [CHANNELS-1:0] VAR_MASK = '0,
   parameter logic [WIDTH-1:0]    RST_VAL  = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en,
   input  logic [idx_w(CHANNELS)-1:0]     wr_ch,
   input  logic [WIDTH-1:0]               wr_data,
   input  logic                           frc_en,
   input  logic [idx_w(CHANNELS)-1:0]     frc_ch,
   input  logic [WIDTH-1:0]               frc_val,
   input  logic [CNT_W-1:0]               frc_cycles,
   input  logic                           rel_en,
   input  logic [idx_w(CHANNELS)-1:0]     rel_ch,
   output logic [CHANNELS*WIDTH-1:0]      dout,
   output logic [CHANNELS-1:0]            forced,
   output logic [CHANNELS-1:0]            rel_pulse
`ifdef FORCE_STATS_EN
   ,
   output logic [CHANNELS*8-1:0]          frc_count
`endif
);

   localparam int IW = idx_w(CHANNELS);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic wr_hit, frc_hit, rel_hit;

      assign wr_hit  = wr_en  && (wr_ch  == IW'(c));
      assign frc_hit = frc_en && (frc_ch == IW'(c));
      assign rel_hit = rel_en && (rel_ch == IW'(c));

      force_release_chan #(
         .WIDTH     (WIDTH),
         .CNT_W     (CNT_W),
         .VAR_STYLE (VAR_MASK[c]),
         .RST_VAL   (RST_VAL)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .wr         (wr_hit),
         .wr_data    (wr_data),
         .frc        (frc_hit),
         .frc_val    (frc_val),
         .frc_cycles (frc_cycles),
         .rel        (rel_hit),
         .dout       (dout[c*WIDTH +: WIDTH]),
         .forced     (forced[c]),
         .rel_pulse  (rel_pulse[c])
`ifdef FORCE_STATS_EN
         ,
         .frc_count  (frc_count[c*8 +: 8])
`endif
      );
   end

endmodule

// File: tb/tb_force_release_bank.sv
module tb_force_release_bank;

   localparam int          W   = 5;
   localparam int          CH  = 3;
   localparam int          CW  = 8;
   localparam int          IW  = 2;
   localparam logic [CH-1:0] VM = 3'b010;
   localparam logic [W-1:0]  RV = 5'd3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            wr_en, frc_en, rel_en;
   logic [IW-1:0]   wr_ch, frc_ch, rel_ch;
   logic [W-1:0]    wr_data, frc_val;
   logic [CW-1:0]   frc_cycles;
   logic [CH*W-1:0] dout;
   logic [CH-1:0]   forced, rel_pulse;
`ifdef FORCE_STATS_EN
   logic [CH*8-1:0] frc_count;
`endif

   force_release_bank #(
      .WIDTH(W), .CHANNELS(CH), .CNT_W(CW), .VAR_MASK(VM), .RST_VAL(RV)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
      .frc_en(frc_en), .frc_ch(frc_ch), .frc_val(frc_val), .frc_cycles(frc_cycles),
      .rel_en(rel_en), .rel_ch(rel_ch),
      .dout(dout), .forced(forced), .rel_pulse(rel_pulse)
`ifdef FORCE_STATS_EN
      , .frc_count(frc_count)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit cmp_on   = 1'b0;

   // Behavioural model: per channel, the register value, the override value,
   // whether an override is active and how many forced cycles remain
   // (0 = indefinite).
   int m_store [CH];
   int m_ovr   [CH];
   bit m_forced[CH];
   int m_left  [CH];
   bit m_pulse [CH];
   int m_cnt   [CH];

   task automatic chk(input string nm, input int c, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s ch%0d got=%0d exp=%0d t=%0t", nm, c, act, exp, $time);
      end
   endtask

   function automatic int dch(input int c);
      return int'(dout[c*W +: W]);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_store[c] = RV; m_ovr[c] = 0; m_forced[c] = 0;
         m_left[c] = 0; m_pulse[c] = 0; m_cnt[c] = 0;
      end
   endtask

   task automatic model_tick();
      if (rst_n) begin
         for (int c = 0; c < CH; c++) begin
            bit w, f, r, was, gone;
            w = wr_en  && (int'(wr_ch)  == c);
            f = frc_en && (int'(frc_ch) == c);
            r = rel_en && (int'(rel_ch) == c);
            was  = m_forced[c];
            gone = 0;
            if (f) begin
               m_ovr[c] = frc_val; m_forced[c] = 1; m_left[c] = frc_cycles;
               if (m_cnt[c] < 255) m_cnt[c]++;
            end else if (was && (r || m_left[c] == 1)) begin
               gone = 1;
            end else if (was && m_left[c] > 1) begin
               m_left[c]--;
            end
            if (!VM[c]) begin
               if (w) m_store[c] = wr_data;
            end else if (gone) begin
               m_store[c] = w ? int'(wr_data) : m_ovr[c];
            end else if (!f && !was && w) begin
               m_store[c] = wr_data;
            end
            if (gone) begin m_forced[c] = 0; m_left[c] = 0; end
            m_pulse[c] = gone;
         end
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         for (int c = 0; c < CH; c++) begin
            chk("dout", c, dch(c), m_forced[c] ? m_ovr[c] : m_store[c]);
            chk("forced", c, int'(forced[c]), int'(m_forced[c]));
            chk("rel_pulse", c, int'(rel_pulse[c]), int'(m_pulse[c]));
`ifdef FORCE_STATS_EN
            chk("frc_count", c, int'(frc_count[c*8 +: 8]), m_cnt[c]);
`endif
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic drive(input bit we, input int wc, input int wd,
                        input bit fe, input int fc, input int fv, input int fcy,
                        input bit re, input int rc);
      wr_en = we;  wr_ch = IW'(wc);  wr_data = W'(wd);
      frc_en = fe; frc_ch = IW'(fc); frc_val = W'(fv); frc_cycles = CW'(fcy);
      rel_en = re; rel_ch = IW'(rc);
      cyc();
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 0; wr_ch = '0; wr_data = '0;
      frc_en = 0; frc_ch = '0; frc_val = '0; frc_cycles = '0;
      rel_en = 0; rel_ch = '0;
      model_reset();
      cmp_on = 1'b1;
      cyc(); cyc();
      for (int c = 0; c < CH; c++) chk("reset_dout", c, dch(c), 3);
      chk("reset_forced", 0, int'(forced), 0);
      chk("reset_pulse", 0, int'(rel_pulse), 0);
      rst_n = 1'b1;

      // net-style ch0: write, force, write-while-forced, release
      drive(1, 0, 6, 0, 0, 0, 0, 0, 0);
      chk("wr_ch0", 0, dch(0), 6);
      chk("wr_forced", 0, int'(forced), 0);
      drive(0, 0, 0, 1, 0, 10, 0, 0, 0);
      chk("frc_ch0", 0, dch(0), 10);
      chk("frc_flag", 0, int'(forced[0]), 1);
      drive(1, 0, 15, 0, 0, 0, 0, 0, 0);
      chk("frc_hold", 0, dch(0), 10);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("net_rel", 0, dch(0), 15);
      chk("net_rel_flag", 0, int'(forced[0]), 0);
      chk("net_pulse", 0, int'(rel_pulse[0]), 1);
      idle();
      chk("pulse_1cyc", 0, int'(rel_pulse[0]), 0);

      // variable-style ch1
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 11, 0, 0, 0);
      drive(1, 1, 15, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("var_rel", 1, dch(1), 11);
      idle(); idle();
      chk("var_keep", 1, dch(1), 11);
      drive(1, 1, 7, 0, 0, 0, 0, 0, 0);
      chk("var_wr", 1, dch(1), 7);

      // timed force ch2, 3 cycles
      drive(0, 0, 0, 1, 2, 10, 3, 0, 0);
      chk("timed_c1", 2, int'(forced[2]), 1);
      chk("timed_val", 2, dch(2), 10);
      idle();
      chk("timed_c2", 2, int'(forced[2]), 1);
      idle();
      chk("timed_c3", 2, int'(forced[2]), 1);
      idle();
      chk("timed_end", 2, int'(forced[2]), 0);
      chk("timed_pulse", 2, int'(rel_pulse[2]), 1);
      chk("timed_dout", 2, dch(2), 3);

      // same-cycle force + release on ch0
      drive(0, 0, 0, 1, 0, 9, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 12, 0, 1, 0);
      chk("frc_rel_flag", 0, int'(forced[0]), 1);
      chk("frc_rel_pulse", 0, int'(rel_pulse[0]), 0);
      chk("frc_rel_val", 0, dch(0), 12);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);

      // variable-style write + release same cycle
      drive(0, 0, 0, 1, 1, 20, 0, 0, 0);
      drive(1, 1, 4, 0, 0, 0, 0, 1, 1);
      chk("var_wr_rel", 1, dch(1), 4);
      chk("var_wr_rel_p", 1, int'(rel_pulse[1]), 1);

      // re-force during timed force
      drive(0, 0, 0, 1, 2, 17, 5, 0, 0);
      idle();
      drive(0, 0, 0, 1, 2, 22, 0, 0, 0);
      repeat (6) idle();
      chk("reforce_flag", 2, int'(forced[2]), 1);
      chk("reforce_val", 2, dch(2), 22);

      // reset mid-force: immediate
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_forced", 0, int'(forced), 0);
      chk("rst_pulse", 0, int'(rel_pulse), 0);
      for (int c = 0; c < CH; c++) chk("rst_dout", c, dch(c), 3);
      cyc(); cyc();
      rst_n = 1'b1;

      // out-of-range channel index
      drive(1, 3, 9, 1, 3, 14, 0, 0, 0);
      idle();
      chk("oor_forced", 0, int'(forced), 0);
      for (int c = 0; c < CH; c++) chk("oor_dout", c, dch(c), 3);

`ifdef FORCE_STATS_EN
      for (int i = 0; i < 300; i++) drive(0, 0, 0, 1, 0, i, 0, 0, 0);
      chk("stat_sat", 0, int'(frc_count[7:0]), 255);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
`endif

      // randomized phase
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            model_reset();
            cyc();
            rst_n = 1'b1;
         end
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom,
               $urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom,
               ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6),
               $urandom_range(0, 3) == 0, $urandom_range(0, 3));
      end

      idle();
      @(negedge clk);
      #1;
      cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
